// File: rtl/linear_dot_product.sv
// linear_dot_product
//   Consumer stage that sits directly after the weight memory fetcher. One
//   pass rewinds the fetcher, streams all M weight lines, multiplies each
//   line against a latched input vector, adds the line bias and emits one
//   saturated neuron result per line through a 2-stage pipeline.
//
// Ports
//   clk        clock
//   clr_n      asynchronous active-low reset
//   start      begin a pass (sampled only while idle)
//   x_in       N signed inputs, PRECISION bits each, element i at [i*PRECISION +: PRECISION]
//   w_in       N signed weights from the fetcher, same packing as x_in
//   bias_in    signed line bias from the fetcher
//   fetch_clr  rewinds the fetcher line counter
//   fetch_ce   fetcher clock enable
//   y_out      signed saturated neuron result
//   y_valid    1-cycle qualifier for y_out / y_idx
//   y_idx      line index of y_out
//   busy       high whenever a pass is in progress
//   done       1-cycle pulse one cycle after the last y_valid
module linear_dot_product #(
  parameter int N              = 5,
  parameter int M              = 5,
  parameter int PRECISION      = 5,
  parameter int BIAS_PRECISION = 32,
  parameter int ACC_WIDTH      = 32,
  parameter int FETCH_LAT      = 2,
  localparam int IDX_W         = (M > 1) ? $clog2(M) : 1
) (
  input  logic                              clk,
  input  logic                              clr_n,
  input  logic                              start,
  input  logic [N*PRECISION-1:0]            x_in,
  input  logic [N*PRECISION-1:0]            w_in,
  input  logic signed [BIAS_PRECISION-1:0]  bias_in,
  output logic                              fetch_clr,
  output logic                              fetch_ce,
  output logic signed [ACC_WIDTH-1:0]       y_out,
  output logic                              y_valid,
  output logic [IDX_W-1:0]                  y_idx,
  output logic                              busy,
  output logic                              done
);

  localparam int PW   = 2 * PRECISION;
  localparam int NSUM = PW + $clog2(N);
  localparam int SW   = ((NSUM > BIAS_PRECISION) ? NSUM : BIAS_PRECISION) + 1;
  localparam int EW   = (SW > ACC_WIDTH) ? SW : ACC_WIDTH;
  localparam int CW   = $clog2(M + FETCH_LAT + 1);

  localparam logic [CW-1:0] FL_C   = CW'(FETCH_LAT);
  localparam logic [CW-1:0] LAST_C = CW'(M + FETCH_LAT - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  // Saturation bounds, sign-extended to the comparison width
  localparam logic signed [EW-1:0] SAT_MAX = EW'($signed({1'b0, {(ACC_WIDTH-1){1'b1}}}));
  localparam logic signed [EW-1:0] SAT_MIN = EW'($signed({1'b1, {(ACC_WIDTH-1){1'b0}}}));

  typedef enum logic [2:0] {IDLE, REWIND, FETCH, DRAIN, DONE} state_t;

  state_t                           state;
  logic [CW-1:0]                    cnt;
  logic signed [PRECISION-1:0]      x_lat   [N];
  logic signed [PW-1:0]             prod    [N];
  logic signed [PW-1:0]             s1_prod [N];
  logic signed [BIAS_PRECISION-1:0] s1_bias;
  logic [IDX_W-1:0]                 s1_idx;
  logic                             s1_valid;
  logic signed [SW-1:0]             sum;
  logic signed [EW-1:0]             sum_ext;
  logic signed [ACC_WIDTH-1:0]      sat;

  // Operands are sign-extended to the full product width first so the
  // multiply is exact.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      prod[i] = PW'(x_lat[i]) * PW'($signed(w_in[i*PRECISION +: PRECISION]));
    end
  end

  always_comb begin
    sum = SW'(s1_bias);
    for (int unsigned i = 0; i < N; i++) begin
      sum = sum + SW'(s1_prod[i]);
    end
    sum_ext = EW'(sum);
    if (sum_ext > SAT_MAX) begin
      sat = ACC_WIDTH'(SAT_MAX);
    end else if (sum_ext < SAT_MIN) begin
      sat = ACC_WIDTH'(SAT_MIN);
    end else begin
      sat = ACC_WIDTH'(sum_ext);
    end
  end

  // Control outputs are registered against the state being entered, so they
  // are valid for exactly the cycles spent in that state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fetch_clr <= 1'b0;
      fetch_ce  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_bias   <= '0;
      s1_idx    <= '0;
      y_out     <= '0;
      y_idx     <= '0;
      y_valid   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        x_lat[i]   <= '0;
        s1_prod[i] <= '0;
      end
    end else begin
      s1_valid <= 1'b0;
      y_valid  <= 1'b0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < N; i++) begin
              x_lat[i] <= $signed(x_in[i*PRECISION +: PRECISION]);
            end
            fetch_clr <= 1'b1;
            busy      <= 1'b1;
            state     <= REWIND;
          end
        end
        REWIND: begin
          fetch_clr <= 1'b0;
          fetch_ce  <= 1'b1;
          cnt       <= '0;
          state     <= FETCH;
        end
        FETCH: begin
          // The first FETCH_LAT cycles only prime the fetcher pipeline.
          if (cnt >= FL_C) begin
            s1_valid <= 1'b1;
            s1_prod  <= prod;
            s1_bias  <= bias_in;
            s1_idx   <= IDX_W'(cnt - FL_C);
          end
          if (cnt == LAST_C) begin
            fetch_ce <= 1'b0;
            cnt      <= '0;
            state    <= DRAIN;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        DRAIN: begin
          if (cnt == ONE_C) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (s1_valid) begin
        y_out   <= sat;
        y_idx   <= s1_idx;
        y_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/linear_dot_product.md
Name: linear_dot_product

Overview:
- Consumer stage directly downstream of the weight memory fetcher in the linear-layer datapath.
- Sequences one pass over all M weight lines:
  - drives the fetcher's clear and clock-enable;
  - captures each line's N signed weights and bias;
  - multiplies the weights element-wise against a latched N-element input vector;
  - sums the products with the bias through a 2-stage pipeline;
  - emits one saturated neuron output per line, tagged with its line index.

Parameters:
- N, 5, inputs per neuron (weights per line)
- M, 5, neurons per pass (weight lines)
- PRECISION, 5, width of each signed weight and each signed input
- BIAS_PRECISION, 32, width of signed bias
- ACC_WIDTH, 32, width of signed saturated output
- FETCH_LAT, 2, cycles from a fetch_ce-high cycle to the corresponding fetcher output becoming visible

Ports:
- clk  in  1  clock
- clr_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- x_in  in  N x PRECISION  signed input vector; latched when start is accepted
- w_in  in  N x PRECISION  signed weights from fetcher data_out
- bias_in  in  BIAS_PRECISION  signed bias from fetcher
- fetch_clr  out  1  clear to fetcher (rewinds its line counter to 0)
- fetch_ce  out  1  clock enable to fetcher
- y_out  out  ACC_WIDTH  signed neuron result
- y_valid  out  1  y_out valid, 1-cycle qualifier
- y_idx  out  clog2(M)  line index of y_out
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse after the last y_valid

Behaviour:
- Reset (clr_n low, asynchronous):
  - state = IDLE;
  - all outputs 0, including y_out, y_idx, fetch_clr and fetch_ce;
  - latched x and pipeline registers cleared.
- Reset mid-pass aborts the pass: no further y_valid, no done.
- FSM:
  - IDLE: on start=1 latch x_in, go to REWIND. While busy, start is ignored.
  - REWIND: 1 cycle; fetch_clr=1, fetch_ce=0; go to FETCH.
  - FETCH: exactly M+FETCH_LAT cycles with fetch_ce=1.
    - Internal cycle counter c runs from 0 to M+FETCH_LAT-1.
    - When c >= FETCH_LAT, sample w_in and bias_in as line k = c-FETCH_LAT into pipeline stage 1.
    - After the last cycle go to DRAIN.
  - DRAIN: 2 cycles, fetch_ce=0; go to DONE.
  - DONE: done=1 for 1 cycle; return to IDLE. start in this cycle is ignored.
- Pipeline:
  - Stage 1 registers the N products p[i] = x[i]*w[i]. Each product is signed, 2*PRECISION bits, exact. Stage 1 also registers the bias and k.
  - Stage 2 computes s = sum(p[i]) + bias at internal width max(2*PRECISION+clog2(N), BIAS_PRECISION)+1, with no overflow.
  - s is saturated to the signed ACC_WIDTH range:
    - s > 2^(ACC_WIDTH-1)-1 gives the maximum;
    - s < -2^(ACC_WIDTH-1) gives the minimum.
  - y_out, y_idx = k and y_valid=1 are registered.
  - Latency from the sampling cycle to y_valid is 2 cycles.
  - y_valid is high for M consecutive cycles per pass, with y_idx incrementing 0..M-1.
  - y_out and y_idx hold their last values when y_valid=0.
- Timing totals per pass:
  - first y_valid appears 1+FETCH_LAT+2 cycles after the REWIND cycle;
  - done follows the last y_valid by exactly 1 cycle;
  - a pass is M+FETCH_LAT+4 cycles from leaving IDLE to re-entering it.
- No backpressure: the consumer must accept every y_valid beat.
- Line counter wrap in the fetcher is irrelevant: REWIND re-zeroes it every pass.
- M=1 is legal, giving a single y_valid beat.

Test Plan:
- Basic pass (defaults): line k has all weights = k and bias = 100*k; x_in all 1 -> y_out = 105*k for k=0..4. y_valid on 5 consecutive cycles with y_idx 0..4, then done 1 cycle later, busy low after that.
- Signed mix: x = {-16,15,-1,0,7}, one line w = {-16,-16,3,5,-2}, bias = -10 -> y = 256-240-3+0-14-10 = -11.
- Saturation with ACC_WIDTH=12: x all -16, w all -16, bias 1000 -> raw 2280 -> y_out = 2047. Bias -5000 with x=0 -> y_out = -2048.
- Protocol timing: check fetch_clr is high exactly 1 cycle before fetch_ce rises, and fetch_ce is high exactly M+2 = 7 cycles. Check the first y_valid occurs 5 cycles after fetch_clr, and start pulses while busy are ignored (no second pass).
- Back-to-back passes: start asserted the cycle after done with a new x_in -> the second pass produces outputs for lines 0..4 again using the new vector, with no stale data.
- Reset mid-pass: deassert clr_n during FETCH c=3 -> all outputs 0 immediately. No done or y_valid follows. A new start then yields a correct full pass.
